// File: rtl/ara_exit_pkg.sv
// Shared types and defaults for the Ara exit monitor.
package ara_exit_pkg;

    // Monitor lifecycle: armed by start, terminal once a verdict is taken.
    typedef enum logic [1:0] {
        Idle = 2'd0,
        Run  = 2'd1,
        Done = 2'd2
    } exit_state_e;

    localparam int unsigned ExitWidthDefault     = 64;
    localparam logic [31:0] TimeoutCyclesDefault = 32'd1_000_000;

endpackage

// File: rtl/ara_exit_latch.sv
// Per-channel sticky exit capture: the first exit seen while enabled wins.
// Besides the registered flag, it exposes the post-capture view (flag and
// code including this cycle's capture) so the top can decide completion in
// the same edge that latches the exit.
module ara_exit_latch
    import ara_exit_pkg::*;
#(
    parameter int unsigned ExitWidth = ExitWidthDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [ExitWidth-1:0] exit_i,
    output logic                 flag_o,
    output logic                 flag_next_o,
    output logic [ExitWidth-2:0] code_next_o
);

    logic                 flag_q;
    logic [ExitWidth-2:0] code_q;
    logic                 capture;

    assign capture = en_i & exit_i[0] & ~flag_q;

    // Post-capture view: a new exit overrides only an empty slot.
    always_comb begin
        flag_next_o = flag_q | capture;
        code_next_o = capture ? exit_i[ExitWidth-1:1] : code_q;
    end

    // Sticky storage of the flag and the captured code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q <= 1'b0;
            // NOTE: the code register is reset as well, so the post-capture
            // view never feeds X into the nonzero-code compare.
            code_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples the pre-edge values regardless of statement order.
            flag_q <= flag_next_o;
            code_q <= code_next_o;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/ara_exit_monitor.sv
// End-of-computation monitor: latches the first exit per channel and takes a
// single registered pass/fail verdict, on the first exit (WaitAll=0) or when
// all channels have exited or any has failed (WaitAll=1).
// Optional watchdog: define ARA_EXIT_WATCHDOG_EN to end hung runs after
// TimeoutCycles cycles in Run; without it Run lasts indefinitely.
module ara_exit_monitor
    import ara_exit_pkg::*;
#(
    parameter int unsigned NrChannels    = 4,
    parameter int unsigned ExitWidth     = ExitWidthDefault,
    parameter bit          WaitAll       = 1'b1,
    parameter logic [31:0] TimeoutCycles = TimeoutCyclesDefault,
    parameter int unsigned IdxWidth      = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [NrChannels*ExitWidth-1:0] exit_i,
    output logic                            done_o,
    output logic                            pass_o,
    output logic [ExitWidth-2:0]            code_o,
    output logic [IdxWidth-1:0]             fail_idx_o,
    output logic [NrChannels-1:0]           exited_o,
    output logic                            timeout_o
);

    exit_state_e state_q;
    logic        run;

    logic [NrChannels-1:0] flag_q;
    logic [NrChannels-1:0] flag_d;
    logic [ExitWidth-2:0]  code_d [NrChannels];
    logic [NrChannels-1:0] fail_vec;

    logic                 any_fail;
    logic [IdxWidth-1:0]  fail_idx_d;
    logic [ExitWidth-2:0] fail_code_d;
    logic                 complete;
    logic                 wd_hit;

    logic                 done_q;
    logic                 pass_q;
    logic [ExitWidth-2:0] code_out_q;
    logic [IdxWidth-1:0]  fail_idx_q;

    assign run = (state_q == Run);

    for (genvar c = 0; c < NrChannels; c++) begin : g_chan
        ara_exit_latch #(
            .ExitWidth (ExitWidth)
        ) u_latch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .en_i        (run),
            .exit_i      (exit_i[c*ExitWidth +: ExitWidth]),
            .flag_o      (flag_q[c]),
            .flag_next_o (flag_d[c]),
            .code_next_o (code_d[c])
        );
        assign fail_vec[c] = flag_d[c] && (code_d[c] != '0);
    end

    // Lowest-index failing channel on the post-capture view.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves one unassigned, which would infer a latch.
        any_fail    = 1'b0;
        fail_idx_d  = '0;
        fail_code_d = '0;
        for (int c = int'(NrChannels) - 1; c >= 0; c--) begin
            if (fail_vec[c]) begin
                any_fail    = 1'b1;
                fail_idx_d  = IdxWidth'(c);
                fail_code_d = code_d[c];
            end
        end
    end

    assign complete = WaitAll ? ((&flag_d) | any_fail) : (|flag_d);

`ifdef ARA_EXIT_WATCHDOG_EN
    logic [31:0] wd_cnt_q;
    logic        timeout_q;

    // Run-cycle counter; restarts from zero whenever the monitor is idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if (state_q == Idle) begin
            wd_cnt_q <= '0;
        end else if (run) begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end

    assign wd_hit    = run && (wd_cnt_q == TimeoutCycles - 32'd1);
    assign timeout_o = timeout_q;
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = TimeoutCycles;
    assign wd_hit                = 1'b0;
    assign timeout_o             = 1'b0;
`endif

    // Lifecycle FSM with the verdict registered on the Run->Done transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= Idle;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            code_out_q <= '0;
            fail_idx_q <= '0;
`ifdef ARA_EXIT_WATCHDOG_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                Idle: begin
                    if (start_i) begin
                        state_q <= Run;
                    end
                end
                Run: begin
                    // Completion takes priority over a watchdog hit in the same cycle.
                    if (complete) begin
                        state_q    <= Done;
                        done_q     <= 1'b1;
                        pass_q     <= ~any_fail;
                        code_out_q <= fail_code_d;
                        fail_idx_q <= fail_idx_d;
                    end else if (wd_hit) begin
                        state_q    <= Done;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        code_out_q <= '1;
                        fail_idx_q <= '0;
`ifdef ARA_EXIT_WATCHDOG_EN
                        timeout_q  <= 1'b1;
`endif
                    end
                end
                Done: begin
                    state_q <= Done;
                end
                default: begin
                    state_q <= Idle;
                end
            endcase
        end
    end

    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign code_o     = code_out_q;
    assign fail_idx_o = fail_idx_q;
    assign exited_o   = flag_q;

endmodule
